// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the multi-precision ALU word sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // ALU function codes; SUB expects cin=1 on the lowest word for two's complement.
  localparam logic [1:0] CTRL_ADD = 2'b00;
  localparam logic [1:0] CTRL_SUB = 2'b01;
  localparam logic [1:0] CTRL_AND = 2'b10;
  localparam logic [1:0] CTRL_OR  = 2'b11;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_word_sel.sv
// Combinational word slicer: presents word idx_i of a wide register, or zero when disabled.
module alu_seq_word_sel #(
  parameter int N     = 4,
  parameter int WORDS = 4,
  parameter int KW    = 2
) (
  input  logic [N*WORDS-1:0] word_i,
  input  logic [KW-1:0]      idx_i,
  input  logic               en_i,
  output logic [N-1:0]       word_o
);

  // Slice the selected word; zero keeps the ALU inputs quiet outside RUN.
  always_comb begin
    word_o = '0;
    if (en_i) begin
      word_o = word_i[idx_i*N +: N];
    end else begin
      word_o = '0;
    end
  end

endmodule

// File: rtl/alu_word_sequencer.sv
// Steps an external N-bit ALU across WORDS words to perform W-bit operations.
// Optional feature macro ALUSEQ_CARRY_CHAIN_EN: chain carries between words (else SIMD lanes).
module alu_word_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N*WORDS-1:0]   op_a,
  input  logic [N*WORDS-1:0]   op_b,
  input  logic                 op_cin,
  input  logic [1:0]           op_ctrl,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   result,
  output logic                 flag_c,
  output logic                 flag_v,
  output logic                 flag_z,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  output logic                 alu_cin,
  output logic [1:0]           alu_ctrl,
  input  logic [N-1:0]         alu_f,
  input  logic                 alu_cout,
  input  logic                 alu_v,
  input  logic                 alu_z
);

  localparam int W  = N * WORDS;
  localparam int KW = clog2(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  seq_state_e     state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [1:0]     ctrl_q, ctrl_d;
  logic           carry_q, carry_d;
  logic           v_q, v_d;
  logic           zacc_q, zacc_d;
  logic [W-1:0]   work_q, work_d;
  logic [W-1:0]   result_q, result_d;
  logic           flag_c_q, flag_c_d;
  logic           flag_v_q, flag_v_d;
  logic           flag_z_q, flag_z_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
`ifndef ALUSEQ_CARRY_CHAIN_EN
  logic           cin_q, cin_d;
`endif

  logic           in_run_s;

  assign in_run_s = (state_q == RUN);

  alu_seq_word_sel #(.N(N), .WORDS(WORDS), .KW(KW)) u_sel_a (
    .word_i (a_q),
    .idx_i  (k_q),
    .en_i   (in_run_s),
    .word_o (alu_a)
  );

  alu_seq_word_sel #(.N(N), .WORDS(WORDS), .KW(KW)) u_sel_b (
    .word_i (b_q),
    .idx_i  (k_q),
    .en_i   (in_run_s),
    .word_o (alu_b)
  );

  assign alu_ctrl = in_run_s ? ctrl_q : 2'b00;
`ifdef ALUSEQ_CARRY_CHAIN_EN
  assign alu_cin  = in_run_s ? carry_q : 1'b0;
`else
  // Lane mode: every word sees the original carry-in; inter-word carries are dropped.
  assign alu_cin  = in_run_s ? cin_q : 1'b0;
`endif

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    carry_d  = carry_q;
    v_d      = v_q;
    zacc_d   = zacc_q;
    work_d   = work_q;
    result_d = result_q;
    flag_c_d = flag_c_q;
    flag_v_d = flag_v_q;
    flag_z_d = flag_z_q;
    done_d   = 1'b0;
`ifndef ALUSEQ_CARRY_CHAIN_EN
    cin_d    = cin_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          ctrl_d  = op_ctrl;
          carry_d = op_cin;
`ifndef ALUSEQ_CARRY_CHAIN_EN
          cin_d   = op_cin;
`endif
          zacc_d  = 1'b1;
          k_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        work_d[k_q*N +: N] = alu_f;
        carry_d = alu_cout;
        v_d     = alu_v;
        zacc_d  = zacc_q & alu_z;
        // Final word: publish from the updated values so the MSW is included.
        if (k_q == K_LAST) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = work_d;
          flag_c_d = alu_cout;
          flag_v_d = alu_v;
          flag_z_d = zacc_q & alu_z;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        k_d     = '0;
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= 2'b00;
      carry_q  <= 1'b0;
      v_q      <= 1'b0;
      zacc_q   <= 1'b0;
      work_q   <= '0;
      result_q <= '0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
      flag_z_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifndef ALUSEQ_CARRY_CHAIN_EN
      cin_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      carry_q  <= carry_d;
      v_q      <= v_d;
      zacc_q   <= zacc_d;
      work_q   <= work_d;
      result_q <= result_d;
      flag_c_q <= flag_c_d;
      flag_v_q <= flag_v_d;
      flag_z_q <= flag_z_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifndef ALUSEQ_CARRY_CHAIN_EN
      cin_q    <= cin_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flag_c = flag_c_q;
  assign flag_v = flag_v_q;
  assign flag_z = flag_z_q;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Scoreboard bench for alu_word_sequencer (N=4, WORDS=4) with a behavioural 4-bit ALU attached.
module tb_alu_word_sequencer;
  import alu_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a, op_b;
  logic        op_cin;
  logic [1:0]  op_ctrl;
  logic        busy, done;
  logic [15:0] result;
  logic        flag_c, flag_v, flag_z;
  logic [3:0]  alu_a, alu_b, alu_f;
  logic        alu_cin, alu_cout, alu_v, alu_z;
  logic [1:0]  alu_ctrl;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  alu_word_sequencer #(.N(4), .WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_ctrl(op_ctrl),
    .busy(busy), .done(done), .result(result),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ctrl(alu_ctrl),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_v(alu_v), .alu_z(alu_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 4-bit ALU
  logic [3:0] bb;
  logic [4:0] sum;
  always_comb begin
    bb       = (alu_ctrl == CTRL_SUB) ? ~alu_b : alu_b;
    sum      = {1'b0, alu_a} + {1'b0, bb} + {4'b0000, alu_cin};
    alu_f    = 4'h0;
    alu_cout = 1'b0;
    alu_v    = 1'b0;
    case (alu_ctrl)
      CTRL_ADD, CTRL_SUB: begin
        alu_f    = sum[3:0];
        alu_cout = sum[4];
        alu_v    = (alu_a[3] == bb[3]) && (sum[3] != alu_a[3]);
      end
      CTRL_AND: alu_f = alu_a & alu_b;
      CTRL_OR:  alu_f = alu_a | alu_b;
      default:  alu_f = 4'h0;
    endcase
    alu_z = (alu_f == 4'h0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  // Monitor: every done pulse retires one expected result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_result"}, {16'h0, result}, {16'h0, e.res});
          chk({e.name, "_c"}, {31'h0, flag_c}, {31'h0, e.c});
          chk({e.name, "_v"}, {31'h0, flag_v}, {31'h0, e.v});
          chk({e.name, "_z"}, {31'h0, flag_z}, {31'h0, e.z});
        end
      end
    end
  end

  task automatic do_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [1:0] ctrl,
                       input logic [15:0] er, input logic ec, input logic ev, input logic ez,
                       input bit inject);
    exp_t e;
    int lat, bcnt, dcnt;
    e.name = nm; e.res = er; e.c = ec; e.v = ev; e.z = ez;
    exp_q.push_back(e);
    @(posedge clk); #1;
    op_a = a; op_b = b; op_cin = cin; op_ctrl = ctrl; start = 1'b1;
    lat = 0; bcnt = 0; dcnt = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (n == 1) start = 1'b0;
      if (inject && n == 3) begin
        start = 1'b1; op_a = 16'h1234; op_b = 16'h4321; op_cin = 1'b1;
      end
      if (inject && n == 4) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat == 0) lat = n;
      end
    end
    chk({nm, "_latency"}, lat, 32'd5);
    chk({nm, "_busy_cycles"}, bcnt, 32'd5);
    chk({nm, "_done_count"}, dcnt, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = 16'h0; op_b = 16'h0; op_cin = 1'b0; op_ctrl = CTRL_ADD;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'h0, busy}, 32'd0);
    chk("reset_done", {31'h0, done}, 32'd0);
    chk("reset_result", {16'h0, result}, 32'd0);
    chk("reset_flags", {29'h0, flag_c, flag_v, flag_z}, 32'd0);
    chk("reset_alu_out", {21'h0, alu_a, alu_b, alu_cin, alu_ctrl}, 32'd0);
    rst_n = 1'b1;

`ifdef ALUSEQ_CARRY_CHAIN_EN
    do_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, CTRL_ADD, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, CTRL_ADD, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op("add_7fff", 16'h7FFF, 16'h0001, 1'b0, CTRL_ADD, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("add_cin",  16'h0000, 16'h0000, 1'b1, CTRL_ADD, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("add_0f00", 16'h0F00, 16'h0100, 1'b0, CTRL_ADD, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    do_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, CTRL_ADD, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, CTRL_ADD, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("add_7fff", 16'h7FFF, 16'h0001, 1'b0, CTRL_ADD, 16'h7FF0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("add_cin",  16'h0000, 16'h0000, 1'b1, CTRL_ADD, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("add_0f00", 16'h0F00, 16'h0100, 1'b0, CTRL_ADD, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    do_op("add_msw_v",  16'h7000, 16'h1000, 1'b0, CTRL_ADD, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("add_lsw_v",  16'h0007, 16'h0001, 1'b0, CTRL_ADD, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("add_msw_c",  16'hF000, 16'h1000, 1'b0, CTRL_ADD, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op("sub_5_3",    16'h0005, 16'h0003, 1'b1, CTRL_SUB, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op("and",        16'hF0F0, 16'h3C3C, 1'b0, CTRL_AND, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ALUSEQ_CARRY_CHAIN_EN
    do_op("ignored_start", 16'h00FF, 16'h0001, 1'b0, CTRL_ADD, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    do_op("ignored_start", 16'h00FF, 16'h0001, 1'b0, CTRL_ADD, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Reset in the middle of RUN: partial work is discarded and no done appears.
    @(posedge clk); #1;
    op_a = 16'hFFFF; op_b = 16'h0001; op_cin = 1'b0; op_ctrl = CTRL_ADD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrun_reset_busy", {31'h0, busy}, 32'd0);
    chk("midrun_reset_done", {31'h0, done}, 32'd0);
    chk("midrun_reset_result", {16'h0, result}, 32'd0);
    chk("midrun_reset_flags", {29'h0, flag_c, flag_v, flag_z}, 32'd0);
    chk("midrun_reset_alu_a", {28'h0, alu_a}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_reset_idle", {31'h0, busy}, 32'd0);
    do_op("post_reset_op", 16'h7000, 16'h1000, 1'b0, CTRL_ADD, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("pending_expected", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_word_sequencer.md
Name: alu_word_sequencer

Overview:
- Multi-precision execute front-end that sits directly around the n-bit ALU. It feeds the ALU one N-bit word per cycle and consumes the ALU's f/cout/v/z outputs.
- Latches a WORDS*N-bit operand pair on start, steps the ALU from the LSW to the MSW with carry chained between words, and assembles the wide result.
- Merges per-word flags into final C/V/Z and reports completion with a done pulse.
- The ALU stays a separate combinational instance; this block owns all sequencing and registers.

Parameters:
- N, 4, ALU word width; must match the ALU's width parameter.
- WORDS, 4, number of words per operation; must be ≥2. Total width W = N*WORDS.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; accepted only in IDLE
- op_a  in  W  operand A
- op_b  in  W  operand B
- op_cin  in  1  carry-in to word 0
- op_ctrl  in  2  ALU function code; held for the whole operation
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; result and flags are valid on and after it
- result  out  W  assembled result
- flag_c  out  1  final carry
- flag_v  out  1  final overflow
- flag_z  out  1  whole-result zero
- alu_a  out  N  word to ALU input a
- alu_b  out  N  word to ALU input b
- alu_cin  out  1  to ALU cin
- alu_ctrl  out  2  to ALU ctrl
- alu_f  in  N  from ALU f
- alu_cout  in  1  from ALU cout
- alu_v  in  1  from ALU v
- alu_z  in  1  from ALU z

Behaviour:
- Reset: all outputs 0, state IDLE, word index k=0, internal registers cleared. Reset has priority over every other event, including mid-RUN; a partial result is discarded and done never fires.
- IDLE:
  - start=1 latches op_a, op_b, op_ctrl into registers.
  - Sets carry_reg=op_cin, zacc=1, k=0, then goes to RUN.
  - start is ignored outside IDLE; no queueing.
- RUN, cycle k:
  - alu_a = a_reg[k*N +: N], alu_b = b_reg[k*N +: N], alu_ctrl = ctrl_reg, alu_cin = carry_reg.
  - At the clock edge: word k of work_reg <= alu_f, carry_reg <= alu_cout, v_reg <= alu_v, zacc <= zacc & alu_z.
  - If k==WORDS-1, go to DONE; otherwise k++.
- DONE (one cycle):
  - done=1.
  - result, flag_c, flag_v and flag_z are loaded from work_reg, carry_reg, v_reg and zacc on the edge entering DONE.
  - Next state is IDLE.
- Output hold: result and flags hold until the next operation's DONE. They never show partial words.
- Outside RUN: alu_* outputs are driven 0.
- Latency: start accepted at edge 0, done high in cycle WORDS+1; back-to-back throughput is one op per WORDS+2 cycles.
- Flag rules:
  - flag_v comes from the MSW only.
  - flag_z = 1 only if every word is zero.
  - flag_c = carry out of the MSW.
- No arithmetic is done locally; all data-path math comes from the ALU.

Optional Feature:
- ALUSEQ_CARRY_CHAIN_EN defined (default build): alu_cin for word k>0 = cout of word k-1, which gives true W-bit arithmetic.
- Undefined (SIMD lane mode): every word uses op_cin and word carries are dropped. flag_c = cout of the MSW lane; V and Z rules are unchanged.

Decomposition:
- Package alu_seq_pkg holds:
  - the state enum IDLE/RUN/DONE;
  - the ctrl code constants (CTRL_ADD etc.) shared with the ALU's users;
  - the function clog2 used to size k.
- One natural sub-module: alu_seq_word_sel. It is a combinational word slicer that picks word k from a W-bit register for alu_a/alu_b, instantiated twice.

Test Plan (N=4, WORDS=4, ctrl=CTRL_ADD, real ALU attached):
- 0x00FF+0x0001, cin=0 -> result 0x0100, c=0, v=0, z=0; done exactly 5 cycles after the start edge.
- 0xFFFF+0x0001, cin=0 -> result 0x0000, c=1, z=1, v=0.
- 0x7FFF+0x0001 -> 0x8000, v=1, c=0; 0x0000+0x0000, cin=1 -> 0x0001, z=0.
- Second start pulsed during RUN -> ignored. Result of the first op is unchanged, only one done pulse, busy stays high for 5 cycles.
- rst_n low at k=2 -> next cycle busy=0, outputs 0, no done. A new start afterwards completes normally.
- Build without ALUSEQ_CARRY_CHAIN_EN: 0x00FF+0x0001 -> 0x00F0, c=0.
